// File: rtl/bec_csla_pkg.sv
// Shared helpers for the pipelined BEC carry-select adder: parameter legality and
// the number of carry-select groups each pipeline stage evaluates.
package bec_csla_pkg;

    function automatic bit params_ok(input int unsigned width, input int unsigned block,
                                     input int unsigned stages);
        int unsigned groups;
        if (block == 0 || stages == 0) return 1'b0;
        if (width % block != 0) return 1'b0;
        groups = width / block;
        return (groups % stages == 0) && (stages <= groups);
    endfunction

    function automatic int unsigned groups_per_stage(input int unsigned width,
                                                     input int unsigned block,
                                                     input int unsigned stages);
        if (block == 0 || stages == 0) return 1;
        return (width / block) / stages;
    endfunction

endpackage

// File: rtl/bec_csla_if.sv
// Operand/result stream bundle for the BEC carry-select adder/subtractor.
interface bec_csla_if #(
    parameter int unsigned WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output in_valid, a, b, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );

    modport slave (
        input  in_valid, a, b, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );
endinterface

// File: rtl/bec_csla_group.sv
// One carry-select group: ripple sum assuming cin=0, its excess-1 (BEC) form for
// cin=1, and the late select on the real incoming carry.
module bec_csla_group #(
    parameter int unsigned BLOCK = 4
) (
    input  logic [BLOCK-1:0] a,
    input  logic [BLOCK-1:0] b,
    input  logic             cin,
    output logic [BLOCK-1:0] sum,
    output logic             cout
);
    logic [BLOCK:0] r0;
    logic [BLOCK:0] r1;
    logic           rc;
    logic           bt;

    // Ripple adder with carry-in tied low
    always_comb begin
        r0 = '0;
        rc = 1'b0;
        for (int i = 0; i < BLOCK; i++) begin
            r0[i] = a[i] ^ b[i] ^ rc;
            rc    = (a[i] & b[i]) | (rc & (a[i] ^ b[i]));
        end
        r0[BLOCK] = rc;
    end

    // Binary-to-excess-1: increment of the cin=0 result including its carry bit
    always_comb begin
        r1 = '0;
        bt = 1'b1;
        for (int i = 0; i <= BLOCK; i++) begin
            r1[i] = r0[i] ^ bt;
            bt    = bt & r0[i];
        end
    end

    assign {cout, sum} = cin ? r1 : r0;
endmodule

// File: rtl/bec_csla_pipe.sv
// Pipelined BEC carry-select adder/subtractor with a valid/ready stream and a
// single global advance; each stage resolves a contiguous slice of groups.
module bec_csla_pipe
    import bec_csla_pkg::*;
#(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned BLOCK  = 4,
    parameter int unsigned STAGES = 2
) (
    input  logic      clk,
    input  logic      rst,
    bec_csla_if.slave bus
);
    localparam int unsigned G    = groups_per_stage(WIDTH, BLOCK, STAGES);
    localparam int unsigned SW   = G * BLOCK;
    localparam int unsigned LAST = STAGES - 1;

    if (!params_ok(WIDTH, BLOCK, STAGES)) begin : g_param_check
        $error("bec_csla_pipe: WIDTH/BLOCK/STAGES combination is not legal");
    end

    logic             advance;
    logic [WIDTH-1:0] bx;
    logic             ovf_c;
    logic             out_valid_q;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             ovf_q;

    assign advance      = !out_valid_q | bus.out_ready;
    assign bus.in_ready = advance;
    assign bx           = bus.b ^ {WIDTH{bus.sub}};

    // Each stage consumes its low SW operand bits and appends SW bits of sum
    for (genvar s = 0; s < STAGES; s++) begin : stg
        localparam int unsigned CONS = s * SW;
        localparam int unsigned REM  = WIDTH - CONS;

        logic [REM-1:0]     op_a;
        logic [REM-1:0]     op_bx;
        logic               vld;
        logic [G:0]         cc;
        logic [SW-1:0]      seg;
        logic [CONS+SW-1:0] acc;

        if (s == 0) begin : g_src
            assign op_a  = bus.a;
            assign op_bx = bx;
            assign cc[0] = bus.sub;
            assign vld   = bus.in_valid;
            assign acc   = seg;
        end else begin : g_src
            logic [CONS-1:0] r_sum;
            logic [REM-1:0]  r_a;
            logic [REM-1:0]  r_bx;
            logic            r_c;
            logic            r_v;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_v   <= 1'b0;
                    r_c   <= 1'b0;
                    r_sum <= '0;
                    r_a   <= '0;
                    r_bx  <= '0;
                end else if (advance) begin
                    r_v   <= stg[s-1].vld;
                    r_c   <= stg[s-1].cc[G];
                    r_sum <= stg[s-1].acc;
                    r_a   <= stg[s-1].op_a[REM+SW-1:SW];
                    r_bx  <= stg[s-1].op_bx[REM+SW-1:SW];
                end
            end

            assign op_a  = r_a;
            assign op_bx = r_bx;
            assign cc[0] = r_c;
            assign vld   = r_v;
            assign acc   = {seg, r_sum};
        end

        for (genvar j = 0; j < G; j++) begin : grp
            bec_csla_group #(.BLOCK(BLOCK)) u_grp (
                .a    (op_a[j*BLOCK +: BLOCK]),
                .b    (op_bx[j*BLOCK +: BLOCK]),
                .cin  (cc[j]),
                .sum  (seg[j*BLOCK +: BLOCK]),
                .cout (cc[j+1])
            );
        end
    end

    // Signed overflow: operands agree in sign but the result does not
    assign ovf_c = (stg[LAST].op_a[SW-1] == stg[LAST].op_bx[SW-1]) &
                   (stg[LAST].acc[WIDTH-1] != stg[LAST].op_a[SW-1]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
        end else if (advance) begin
            out_valid_q <= stg[LAST].vld;
            if (stg[LAST].vld) begin
                sum_q  <= stg[LAST].acc;
                cout_q <= stg[LAST].cc[G];
                ovf_q  <= ovf_c;
            end
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;
    assign bus.ovf       = ovf_q;
endmodule
